// File: rtl/bitwise_unit_pipe.sv
// Registered WIDTH-bit AND/OR/XOR/NOR unit with a valid/ready handshake and a
// burst accumulate mode that folds a stream of beats into one result.
module bitwise_unit_pipe #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             last,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             zero,
   output logic [CNTW-1:0]  beats
);

   typedef enum logic {IDLE, ACC} state_t;
   typedef enum logic [1:0] {C_OR, C_AND, C_XOR} comb_t;

   function automatic logic [WIDTH-1:0] combine(comb_t c, logic [WIDTH-1:0] x,
                                                logic [WIDTH-1:0] y);
      case (c)
         C_AND:   return x & y;
         C_XOR:   return x ^ y;
         default: return x | y;
      endcase
   endfunction

   state_t            state, state_nx;
   comb_t             burst_comb, burst_nx, req_comb, cur_comb;
   logic [WIDTH-1:0]  acc, acc_nx, pair, folded, elem, res;
   logic [CNTW-1:0]   cnt, cnt_nx, cnt_inc, res_beats;
   logic              accept, is_acc_op, load;

   assign in_ready  = !reset && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_acc_op = op[2] && (op != 3'b111);

   always_comb begin
      case (op[1:0])
         2'b01:   req_comb = C_AND;
         2'b10:   req_comb = C_XOR;
         default: req_comb = C_OR;
      endcase
   end

   // Once a burst is open the latched combine op wins over whatever op says.
   assign cur_comb = (state == ACC) ? burst_comb : req_comb;
   assign pair     = combine(cur_comb, A, B);
   assign folded   = combine(cur_comb, acc, pair);
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNTW'(1);

   always_comb begin
      case (op)
         3'b000:  elem = A & B;
         3'b010:  elem = A ^ B;
         3'b011:  elem = ~(A | B);
         default: elem = A | B;
      endcase
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      cnt_nx    = cnt;
      burst_nx  = burst_comb;
      load      = 1'b0;
      res       = elem;
      res_beats = CNTW'(1);
      if (accept) begin
         if (state == ACC) begin
            if (last) begin
               load      = 1'b1;
               res       = folded;
               res_beats = cnt_inc;
               acc_nx    = '0;
               cnt_nx    = '0;
               state_nx  = IDLE;
            end else begin
               acc_nx = folded;
               cnt_nx = cnt_inc;
            end
         end else if (is_acc_op) begin
            if (last) begin
               load = 1'b1;
               res  = pair;
            end else begin
               // identity of the combine op folded with pair is just pair
               acc_nx   = pair;
               cnt_nx   = CNTW'(1);
               burst_nx = req_comb;
               state_nx = ACC;
            end
         end else begin
            load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         burst_comb <= C_OR;
         acc        <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         R          <= '0;
         zero       <= 1'b0;
         beats      <= '0;
      end else begin
         state      <= state_nx;
         burst_comb <= burst_nx;
         acc        <= acc_nx;
         cnt        <= cnt_nx;
         if (load) begin
            out_valid <= 1'b1;
            R         <= res;
            zero      <= (res == '0);
            beats     <= res_beats;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Directed bench for bitwise_unit_pipe: a CNTW=8 instance for the main checks
// and a CNTW=2 instance sharing the same stimulus for counter saturation.
module tb_bitwise_unit_pipe;

   logic        clk = 1'b0;
   logic        reset, in_valid, last, out_ready;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        in_ready, out_valid, zero;
   logic [31:0] R;
   logic [7:0]  beats;
   logic        in_ready2, out_valid2, zero2;
   logic [31:0] R2;
   logic [1:0]  beats2;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   bitwise_unit_pipe #(.WIDTH(32), .CNTW(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .last(last), .A(A), .B(B), .out_valid(out_valid),
      .out_ready(out_ready), .R(R), .zero(zero), .beats(beats));

   bitwise_unit_pipe #(.WIDTH(32), .CNTW(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .last(last), .A(A), .B(B), .out_valid(out_valid2),
      .out_ready(out_ready), .R(R2), .zero(zero2), .beats(beats2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one beat for exactly one edge, then sample 1 time unit later.
   task automatic beat(input logic [2:0] o, input logic l, input logic [31:0] a,
                       input logic [31:0] b);
      op = o; last = l; A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; last = 1'b0; out_ready = 1'b1;
      op = 3'b000; A = '0; B = '0;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_R", R, 0);
      chk("rst_zero", zero, 0);
      chk("rst_beats", beats, 0);
      reset = 1'b0; #1;
      chk("post_rst_in_ready", in_ready, 1);

      // element ops, back to back
      beat(3'b000, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("and_v", out_valid, 1); chk("and_R", R, 32'h00F0_00F0);
      chk("and_beats", beats, 1); chk("and_zero", zero, 0);
      beat(3'b001, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("or_v", out_valid, 1); chk("or_R", R, 32'hFFF0_FFF0); chk("or_beats", beats, 1);
      beat(3'b010, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("xor_v", out_valid, 1); chk("xor_R", R, 32'hFF00_FF00);
      beat(3'b011, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("nor_v", out_valid, 1); chk("nor_R", R, 32'h000F_000F); chk("nor_zero", zero, 0);
      beat(3'b111, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("op7_R", R, 32'hFFF0_FFF0); chk("op7_beats", beats, 1);
      idle();
      chk("drain_v", out_valid, 0);

      // OR-acc burst of 4
      beat(3'b100, 0, 32'h1, 0); chk("oracc_b1_v", out_valid, 0);
      beat(3'b100, 0, 32'h2, 0); chk("oracc_b2_v", out_valid, 0);
      beat(3'b100, 0, 32'h4, 0); chk("oracc_b3_v", out_valid, 0);
      beat(3'b100, 1, 32'h8, 0);
      chk("oracc_v", out_valid, 1); chk("oracc_R", R, 32'h0000_000F);
      chk("oracc_beats", beats, 4); chk("oracc_sat_beats", beats2, 3);
      idle();

      // AND-acc
      beat(3'b101, 0, 32'hFFFF_0000, 32'hFFFF_FFFF); chk("andacc_b1_v", out_valid, 0);
      beat(3'b101, 1, 32'hF0F0_FFFF, 32'hFFFF_FFFF);
      chk("andacc_R", R, 32'hF0F0_0000); chk("andacc_beats", beats, 2);
      idle();

      // XOR-acc
      beat(3'b110, 0, 32'h1, 0);
      beat(3'b110, 0, 32'h1, 0);
      beat(3'b110, 1, 32'h1, 0);
      chk("xoracc_v", out_valid, 1); chk("xoracc_R", R, 32'h1);
      chk("xoracc_zero", zero, 0); chk("xoracc_beats", beats, 3);
      idle();

      // backpressure: stall 3 cycles with a competing beat offered
      beat(3'b000, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      out_ready = 1'b0;
      op = 3'b001; A = 32'h1234_5678; B = 0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_v", out_valid, 1);
         chk("bp_R", R, 32'h00F0_00F0);
         chk("bp_beats", beats, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      beat(3'b010, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("bp_replace_v", out_valid, 1); chk("bp_replace_R", R, 32'hFF00_FF00);
      idle();
      chk("bp_drain_v", out_valid, 0);

      // saturation on CNTW=2, element op mid-burst ignored
      beat(3'b100, 0, 32'h01, 0);
      beat(3'b100, 0, 32'h02, 0);
      beat(3'b000, 0, 32'h04, 0); chk("sat_mid_v", out_valid, 0);
      beat(3'b000, 0, 32'h08, 0);
      beat(3'b000, 0, 32'h10, 0);
      beat(3'b100, 1, 32'h20, 0);
      chk("sat_R", R2, 32'h3F); chk("sat_beats", beats2, 3);
      chk("nosat_R", R, 32'h3F); chk("nosat_beats", beats, 6);
      idle();

      // reset on beat 2 of a burst
      beat(3'b100, 0, 32'hFF, 0);
      op = 3'b100; last = 1'b0; A = 32'hF00; B = 0; in_valid = 1'b1; reset = 1'b1;
      #1;
      chk("rst_mid_in_ready", in_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_mid_v", out_valid, 0);
      beat(3'b100, 1, 0, 0);
      chk("fresh_v", out_valid, 1); chk("fresh_R", R, 0);
      chk("fresh_zero", zero, 1); chk("fresh_beats", beats, 1);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
